intr_ctrl: RTL and testbench

INTR_CTRL -- requirements
Module: intr_ctrl

---
 rtl/intr_ctrl.sv | 123 ++++++++++++
 tb/tb_intr_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/intr_ctrl.sv
// Eight-source priority interrupt controller for a small MCU I/O bus.
// Edge-detected sources latch into PEND; a REQ/SVC handshake runs through CLAIM and EOI writes.
module intr_ctrl #(
    parameter logic [7:0] BASE_ID = 8'hF0
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic [7:0] IRQ,
    input  logic [7:0] PORT_ID,
    input  logic [7:0] OUT_PORT,
    input  logic       IO_STRB,
    output logic       INTR,
    output logic [7:0] IC_DATA,
    output logic       IC_SEL,
    output logic [1:0] DBG_STATE
);

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_REQ  = 2'b01;
    localparam logic [1:0] ST_SVC  = 2'b10;

    logic [7:0] sync1_q, sync2_q, dly_q;
    logic [7:0] mask_q, mask_d;
    logic [7:0] pend_q, pend_d;
    logic [1:0] state_q, state_d;
    logic [2:0] id_q, id_d;

    logic       wr_en, wr_mask, wr_pend, wr_claim, wr_eoi;
    logic [7:0] irq_rise, elig, w1c_clr, eoi_clr;
    logic [2:0] win;
    logic [7:0] vec;

    assign IC_SEL    = (PORT_ID[7:2] == BASE_ID[7:2]);
    assign wr_en     = IO_STRB & IC_SEL;
    assign wr_mask   = wr_en && (PORT_ID[1:0] == 2'd0);
    assign wr_pend   = wr_en && (PORT_ID[1:0] == 2'd1);
    assign wr_claim  = wr_en && (PORT_ID[1:0] == 2'd2);
    assign wr_eoi    = wr_en && (PORT_ID[1:0] == 2'd3);

    assign irq_rise  = sync2_q & ~dly_q;
    assign elig      = pend_q & mask_q;
    assign INTR      = (state_q == ST_REQ);
    assign DBG_STATE = state_q;
    assign vec       = {INTR, (state_q == ST_SVC), 3'b000, id_q};

    // Lowest index wins: scan downward so the last hit is the highest priority.
    always_comb begin
        win = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (elig[i]) win = i[2:0];
        end
    end

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        eoi_clr = 8'h00;
        case (state_q)
            ST_IDLE: begin
                if (elig != 8'h00) begin
                    state_d = ST_REQ;
                    id_d    = win;
                end
            end
            ST_REQ: begin
                if (elig == 8'h00) begin
                    state_d = ST_IDLE;
                end else if (wr_claim) begin
                    state_d = ST_SVC;
                end else begin
                    id_d = win;
                end
            end
            ST_SVC: begin
                if (wr_eoi) begin
                    state_d = ST_IDLE;
                    eoi_clr = 8'h01 << id_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A fresh edge overrides a same-cycle clear so no request is lost.
    always_comb begin
        w1c_clr = wr_pend ? OUT_PORT : 8'h00;
        pend_d  = (pend_q & ~(w1c_clr | eoi_clr)) | irq_rise;
        mask_d  = wr_mask ? OUT_PORT : mask_q;
    end

    always_comb begin
        IC_DATA = 8'h00;
        if (IC_SEL) begin
            case (PORT_ID[1:0])
                2'd0:    IC_DATA = mask_q;
                2'd1:    IC_DATA = pend_q;
                2'd2:    IC_DATA = vec;
                default: IC_DATA = 8'h00;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            sync1_q <= 8'h00;
            sync2_q <= 8'h00;
            dly_q   <= 8'h00;
            mask_q  <= 8'h00;
            pend_q  <= 8'h00;
            state_q <= ST_IDLE;
            id_q    <= 3'd0;
        end else begin
            sync1_q <= IRQ;
            sync2_q <= sync1_q;
            dly_q   <= sync2_q;
            mask_q  <= mask_d;
            pend_q  <= pend_d;
            state_q <= state_d;
            id_q    <= id_d;
        end
    end

endmodule

// File: tb/tb_intr_ctrl.sv
// Directed bench for intr_ctrl: register access, edge-to-INTR latency, priority,
// masking, set-vs-clear collision and asynchronous reset.
module tb_intr_ctrl;

    localparam logic [7:0] BASE = 8'hF0;

    logic       CLK;
    logic       RESET_N;
    logic [7:0] IRQ;
    logic [7:0] PORT_ID;
    logic [7:0] OUT_PORT;
    logic       IO_STRB;
    logic       INTR;
    logic [7:0] IC_DATA;
    logic       IC_SEL;
    logic [1:0] DBG_STATE;

    int checks = 0;
    int errors = 0;

    intr_ctrl #(.BASE_ID(BASE)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .IRQ(IRQ), .PORT_ID(PORT_ID),
        .OUT_PORT(OUT_PORT), .IO_STRB(IO_STRB), .INTR(INTR),
        .IC_DATA(IC_DATA), .IC_SEL(IC_SEL), .DBG_STATE(DBG_STATE)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic rd(input string tag, input logic [1:0] off, input logic [7:0] exp);
        PORT_ID = {BASE[7:2], off};
        #1;
        chk(tag, IC_DATA, exp);
    endtask

    task automatic chk_intr(input string tag, input logic exp);
        chk(tag, {7'b0, INTR}, {7'b0, exp});
    endtask

    task automatic chk_state(input string tag, input logic [1:0] exp);
        chk(tag, {6'b0, DBG_STATE}, {6'b0, exp});
    endtask

    // Drive in the low phase; the write lands on the next rising edge.
    task automatic wr(input logic [7:0] port, input logic [7:0] data);
        PORT_ID  = port;
        OUT_PORT = data;
        IO_STRB  = 1'b1;
        @(negedge CLK);
        IO_STRB  = 1'b0;
        PORT_ID  = 8'h00;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge CLK);
    endtask

    initial begin
        RESET_N = 1'b0; IRQ = 8'h00; PORT_ID = 8'h00; OUT_PORT = 8'h00; IO_STRB = 1'b0;
        cyc(2);
        chk_intr("rst_intr", 1'b0);
        chk_state("rst_state", 2'b00);
        rd("rst_mask", 2'd0, 8'h00);
        rd("rst_pend", 2'd1, 8'h00);
        rd("rst_vec", 2'd2, 8'h00);
        cyc(1);
        RESET_N = 1'b1;

        // Single source: latency, VEC during REQ/SVC, EOI
        wr(8'hF0, 8'h04);
        rd("a_mask", 2'd0, 8'h04);
        IRQ = 8'h04;
        cyc(1); rd("a_pend_e1", 2'd1, 8'h00);
        cyc(1); rd("a_pend_e2", 2'd1, 8'h00);
        cyc(1); rd("a_pend_e3", 2'd1, 8'h04); chk_intr("a_intr_e3", 1'b0);
        cyc(1); chk_intr("a_intr_e4", 1'b1); rd("a_vec_req", 2'd2, 8'h82);
        wr(8'hF2, 8'hAA);
        chk_intr("a_intr_claim", 1'b0);
        rd("a_vec_svc", 2'd2, 8'h42);
        rd("a_pend_svc", 2'd1, 8'h04);
        wr(8'hF3, 8'h00);
        rd("a_pend_eoi", 2'd1, 8'h00);
        chk_state("a_state_eoi", 2'b00);
        cyc(1);
        rd("a_pend_level", 2'd1, 8'h00);
        chk_intr("a_intr_level", 1'b0);
        IRQ = 8'h00;

        // Preemption before claim, EOI clears only the claimed id
        wr(8'hF0, 8'hFF);
        IRQ = 8'h20; cyc(1); IRQ = 8'h00; cyc(2);
        rd("b_pend5", 2'd1, 8'h20);
        cyc(1);
        chk_intr("b_intr5", 1'b1); rd("b_vec5", 2'd2, 8'h85);
        IRQ = 8'h02; cyc(1); IRQ = 8'h00; cyc(2);
        rd("b_pend51", 2'd1, 8'h22); rd("b_vec_still5", 2'd2, 8'h85);
        cyc(1);
        rd("b_vec1", 2'd2, 8'h81);
        wr(8'hF2, 8'h00);
        rd("b_vec_claim1", 2'd2, 8'h41); chk_intr("b_intr_claim", 1'b0);
        wr(8'hF3, 8'h00);
        rd("b_pend_eoi", 2'd1, 8'h20); chk_state("b_state_eoi", 2'b00);
        cyc(1);
        chk_intr("b_intr_rearb", 1'b1); rd("b_vec_rearb", 2'd2, 8'h85);
        wr(8'hF2, 8'h00); wr(8'hF3, 8'h00);
        rd("b_pend_clean", 2'd1, 8'h00);

        // Masking while in REQ
        IRQ = 8'h08; cyc(1); IRQ = 8'h00; cyc(3);
        chk_intr("c_intr3", 1'b1); rd("c_vec3", 2'd2, 8'h83);
        wr(8'hF0, 8'h00);
        chk_intr("c_intr_maskedge", 1'b1);
        cyc(1);
        chk_intr("c_intr_masked", 1'b0); rd("c_pend_kept", 2'd1, 8'h08);
        chk_state("c_state_masked", 2'b00);
        wr(8'hF0, 8'h08);
        chk_intr("c_intr_unmaskedge", 1'b0);
        cyc(1);
        chk_intr("c_intr_back", 1'b1); rd("c_vec_back", 2'd2, 8'h83);
        wr(8'hF2, 8'h00); wr(8'hF3, 8'h00);
        rd("c_pend_clean", 2'd1, 8'h00);

        // New edge on id 0 lands on the same edge as its EOI
        wr(8'hF0, 8'hFF);
        IRQ = 8'h01; cyc(1); IRQ = 8'h00; cyc(3);
        chk_intr("d_intr0", 1'b1); rd("d_vec0", 2'd2, 8'h80);
        wr(8'hF2, 8'h00);
        rd("d_vec_svc", 2'd2, 8'h40);
        IRQ = 8'h01; cyc(1); IRQ = 8'h00; cyc(1);
        wr(8'hF3, 8'h00);
        rd("d_pend_setwins", 2'd1, 8'h01);
        chk_state("d_state_eoi", 2'b00);
        cyc(1);
        chk_intr("d_intr_again", 1'b1); rd("d_vec_again", 2'd2, 8'h80);
        wr(8'hF2, 8'h00); wr(8'hF3, 8'h00);
        rd("d_pend_clean", 2'd1, 8'h00);

        // Asynchronous reset in SVC discards everything
        IRQ = 8'h21; cyc(1); IRQ = 8'h00; cyc(3);
        rd("e_vec_req0", 2'd2, 8'h80);
        wr(8'hF2, 8'h00);
        rd("e_pend21", 2'd1, 8'h21);
        chk_state("e_state_svc", 2'b10);
        @(negedge CLK);
        #1 RESET_N = 1'b0;
        IRQ = 8'h10;
        #1;
        chk_intr("e_intr_rst", 1'b0);
        chk_state("e_state_rst", 2'b00);
        rd("e_pend_rst", 2'd1, 8'h00);
        cyc(1);
        rd("e_mask_rst", 2'd0, 8'h00);
        rd("e_vec_rst", 2'd2, 8'h00);

        // IRQ already high at reset release counts as an edge
        cyc(1);
        RESET_N = 1'b1;
        cyc(2); rd("f_pend_e2", 2'd1, 8'h00);
        cyc(1); rd("f_pend_e3", 2'd1, 8'h10); chk_state("f_state_masked", 2'b00);
        wr(8'hF1, 8'h10);
        rd("f_pend_w1c", 2'd1, 8'h00);
        cyc(1);
        rd("f_pend_level", 2'd1, 8'h00);
        IRQ = 8'h00;

        // W1C of one bit, ignored claim, off-block writes and selects
        IRQ = 8'h03; cyc(1); IRQ = 8'h00; cyc(2);
        rd("g_pend03", 2'd1, 8'h03);
        chk_intr("g_intr_masked", 1'b0);
        wr(8'hF1, 8'h01);
        rd("g_pend_w1c", 2'd1, 8'h02);
        wr(8'hF2, 8'h00);
        chk_state("g_claim_ignored", 2'b00);
        PORT_ID = 8'h44; OUT_PORT = 8'hFF; IO_STRB = 1'b1;
        #1;
        chk("g_sel_off", {7'b0, IC_SEL}, 8'h00);
        chk("g_data_off", IC_DATA, 8'h00);
        @(negedge CLK);
        PORT_ID = 8'hF4; OUT_PORT = 8'hFF; IO_STRB = 1'b1;
        #1;
        chk("g_sel_f4", {7'b0, IC_SEL}, 8'h00);
        @(negedge CLK);
        IO_STRB = 1'b0;
        rd("g_mask_kept", 2'd0, 8'h00);
        rd("g_pend_kept", 2'd1, 8'h02);
        rd("g_eoi_read", 2'd3, 8'h00);
        chk("g_sel_f3", {7'b0, IC_SEL}, 8'h01);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
